// File: rtl/ddr4_iod_dly_step_ctrl.sv
// Step sequencer for one DDR4 PHY IOD dynamic delay line: LOAD/MOVE commands, settle spacing, tap tracking.
// Optional build macro IOD_DLY_CTRL_SOFT_LIMIT_EN stops a move before it would leave 0..MAX_TAP.
module ddr4_iod_dly_step_ctrl #(
    parameter int TAP_W         = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int LOAD_TAP      = 1,
    parameter int MAX_TAP       = 255
) (
    input  logic             FAB_CLK,
    input  logic             ARST_N,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic             CMD_OP,
    input  logic             CMD_DIR,
    input  logic [TAP_W-1:0] CMD_STEPS,
    output logic             DONE,
    output logic             DONE_OOR,
    output logic [TAP_W-1:0] TAP_POS,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    input  logic             DELAY_LINE_OUT_OF_RANGE,
    output logic [2:0]       state_dbg
);

    // Handshake: a command transfers on a rising edge where CMD_VALID && CMD_READY;
    // CMD_READY is high only in IDLE and the command fields are captured on that edge.

    localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
    localparam logic [CW-1:0]    SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [TAP_W-1:0] LOAD_TAP_L  = TAP_W'(LOAD_TAP);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_MOVE   = 3'd2,
        S_SETTLE = 3'd3,
        S_FIN    = 3'd4
    } state_t;

    state_t            state;
    logic [CW-1:0]     settle_cnt;
    logic [TAP_W-1:0]  steps_q;
    logic              dir_q;
    logic              is_load;
    logic [TAP_W-1:0]  tap_step;
    logic              lim_accept;
    logic              lim_next;

    assign tap_step = dir_q ? (TAP_POS + 1'b1) : (TAP_POS - 1'b1);

`ifdef IOD_DLY_CTRL_SOFT_LIMIT_EN
    localparam logic [TAP_W-1:0] MAX_TAP_L = TAP_W'(MAX_TAP);
    assign lim_accept = CMD_DIR ? (TAP_POS >= MAX_TAP_L) : (TAP_POS == '0);
    assign lim_next   = dir_q ? (tap_step >= MAX_TAP_L) : (tap_step == '0);
`else
    assign lim_accept = 1'b0;
    assign lim_next   = 1'b0;
`endif

    // In IDLE the direction follows the offered command so it is already settled
    // during the accept cycle, one cycle ahead of the first MOVE pulse.
    assign DELAY_LINE_DIRECTION = (state == S_IDLE) ? (CMD_VALID & CMD_DIR) : dir_q;
    assign state_dbg = state;

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state           <= S_IDLE;
            settle_cnt      <= '0;
            steps_q         <= '0;
            dir_q           <= 1'b0;
            is_load         <= 1'b0;
            CMD_READY       <= 1'b1;
            DONE            <= 1'b0;
            DONE_OOR        <= 1'b0;
            TAP_POS         <= LOAD_TAP_L;
            DELAY_LINE_LOAD <= 1'b0;
            DELAY_LINE_MOVE <= 1'b0;
        end else begin
            DONE            <= 1'b0;
            DELAY_LINE_LOAD <= 1'b0;
            DELAY_LINE_MOVE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (CMD_VALID) begin
                        CMD_READY <= 1'b0;
                        DONE_OOR  <= 1'b0;
                        dir_q     <= CMD_DIR;
                        steps_q   <= CMD_STEPS;
                        is_load   <= CMD_OP;
                        if (CMD_OP) begin
                            state           <= S_LOAD;
                            DELAY_LINE_LOAD <= 1'b1;
                        end else if (CMD_STEPS == '0) begin
                            state <= S_FIN;
                        end else if (lim_accept) begin
                            DONE_OOR <= 1'b1;
                            state    <= S_FIN;
                        end else begin
                            state           <= S_MOVE;
                            DELAY_LINE_MOVE <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    TAP_POS    <= LOAD_TAP_L;
                    settle_cnt <= SETTLE_LAST;
                    state      <= S_SETTLE;
                end
                S_MOVE: begin
                    settle_cnt <= SETTLE_LAST;
                    state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end else if (is_load) begin
                        DONE  <= 1'b1;
                        state <= S_FIN;
                    end else if (DELAY_LINE_OUT_OF_RANGE) begin
                        DONE_OOR <= 1'b1;
                        DONE     <= 1'b1;
                        state    <= S_FIN;
                    end else begin
                        TAP_POS <= tap_step;
                        steps_q <= steps_q - 1'b1;
                        if (steps_q == TAP_W'(1)) begin
                            DONE  <= 1'b1;
                            state <= S_FIN;
                        end else if (lim_next) begin
                            DONE_OOR <= 1'b1;
                            DONE     <= 1'b1;
                            state    <= S_FIN;
                        end else begin
                            DELAY_LINE_MOVE <= 1'b1;
                            state           <= S_MOVE;
                        end
                    end
                end
                S_FIN: begin
                    // Entered straight from IDLE when no pulse was issued: spend one
                    // extra cycle here so DONE lands two cycles after accept.
                    if (!DONE) begin
                        DONE <= 1'b1;
                    end else begin
                        CMD_READY <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    CMD_READY <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr4_iod_dly_step_ctrl.sv
// Bench for ddr4_iod_dly_step_ctrl: scoreboard of expected DONE cycle/tap/OOR plus pulse logs.
module tb_ddr4_iod_dly_step_ctrl;
    localparam int TAP_W = 8;
    localparam int S     = 4;
    localparam int EW    = 20 + TAP_W + 1;

    logic             FAB_CLK = 1'b0;
    logic             ARST_N;
    logic             CMD_VALID;
    logic             CMD_READY;
    logic             CMD_OP;
    logic             CMD_DIR;
    logic [TAP_W-1:0] CMD_STEPS;
    logic             DONE;
    logic             DONE_OOR;
    logic [TAP_W-1:0] TAP_POS;
    logic             DELAY_LINE_LOAD;
    logic             DELAY_LINE_MOVE;
    logic             DELAY_LINE_DIRECTION;
    logic             DELAY_LINE_OUT_OF_RANGE;
    logic [2:0]       state_dbg;

    ddr4_iod_dly_step_ctrl #(.TAP_W(TAP_W), .SETTLE_CYCLES(S), .LOAD_TAP(1), .MAX_TAP(255)) dut (
        .FAB_CLK(FAB_CLK), .ARST_N(ARST_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_DIR(CMD_DIR), .CMD_STEPS(CMD_STEPS), .DONE(DONE),
        .DONE_OOR(DONE_OOR), .TAP_POS(TAP_POS), .DELAY_LINE_LOAD(DELAY_LINE_LOAD),
        .DELAY_LINE_MOVE(DELAY_LINE_MOVE), .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
        .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 FAB_CLK = ~FAB_CLK;

    int cyc = 0;
    always @(posedge FAB_CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int acc_cyc = 0;
    int done_cnt = 0;
    logic exp_dir = 1'b0;
    logic [EW-1:0] exp_q[$];
    int mv_q[$];
    int ld_q[$];

    // scoreboard monitor
    always @(negedge FAB_CLK) begin
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        if (ARST_N) begin
            if (DELAY_LINE_MOVE) begin
                mv_q.push_back(cyc - acc_cyc);
                checks++;
                if (DELAY_LINE_DIRECTION !== exp_dir) begin
                    errors++;
                    $display("FAIL move_dir: got %b want %b", DELAY_LINE_DIRECTION, exp_dir);
                end
            end
            if (DELAY_LINE_LOAD) ld_q.push_back(cyc - acc_cyc);
            if (DONE) begin
                done_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: DONE at cycle %0d with nothing expected", cyc - acc_cyc);
                end else begin
                    e = exp_q.pop_front();
                    a = {cyc[19:0], TAP_POS, DONE_OOR};
                    if (a !== e) begin
                        errors++;
                        $display("FAIL done_result: got cycle %0d tap %0d oor %b, want cycle %0d tap %0d oor %b",
                                 cyc - acc_cyc, TAP_POS, DONE_OOR,
                                 int'(e[EW-1 -: 20]) - acc_cyc, e[TAP_W:1], e[0]);
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic apply_reset();
        ARST_N = 1'b0;
        CMD_VALID = 1'b0; CMD_OP = 1'b0; CMD_DIR = 1'b0; CMD_STEPS = '0;
        DELAY_LINE_OUT_OF_RANGE = 1'b0;
        repeat (3) @(negedge FAB_CLK);
        ARST_N = 1'b1;
        @(negedge FAB_CLK);
    endtask

    task automatic send_cmd(input logic op, input logic dir, input int steps,
                            input int lat, input int exp_tap, input logic exp_oor, input logic hold);
        int budget;
        budget = 400;
        @(negedge FAB_CLK);
        while (!CMD_READY && budget > 0) begin
            @(negedge FAB_CLK);
            budget--;
        end
        if (budget == 0) begin
            checks++; errors++;
            $display("FAIL ready_timeout: CMD_READY stayed 0");
        end
        mv_q.delete();
        ld_q.delete();
        acc_cyc = cyc;
        exp_dir = dir;
        CMD_VALID = 1'b1; CMD_OP = op; CMD_DIR = dir; CMD_STEPS = TAP_W'(steps);
        exp_q.push_back({20'(acc_cyc + lat), TAP_W'(exp_tap), exp_oor});
        @(posedge FAB_CLK);
        #1;
        if (!hold) begin
            CMD_VALID = 1'b0;
            CMD_OP = $urandom_range(0, 1) != 0;
            CMD_DIR = $urandom_range(0, 1) != 0;
            CMD_STEPS = TAP_W'($urandom_range(0, 255));
        end
    endtask

    task automatic wait_done(input string name);
        int budget;
        budget = 2000;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge FAB_CLK);
            budget--;
        end
        if (budget == 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: DONE never arrived", name);
            exp_q.delete();
        end
        @(negedge FAB_CLK);
    endtask

    task automatic check_moves(input string name, input int n, input int first);
        checks++;
        if (mv_q.size() != n) begin
            errors++;
            $display("FAIL %s_pulses: got %0d MOVE pulses want %0d", name, mv_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (mv_q[i] != first + i * (S + 1)) begin
                    errors++;
                    $display("FAIL %s_pulse%0d: got cycle %0d want %0d", name, i, mv_q[i], first + i * (S + 1));
                end
            end
        end
    endtask

    // scenarios
    task automatic test_reset();
        apply_reset();
        checks++;
        if ({CMD_READY, DONE, DONE_OOR, DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 100000",
                     {CMD_READY, DONE, DONE_OOR, DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION});
        end
        checks++;
        if (TAP_POS !== 8'd1) begin
            errors++;
            $display("FAIL reset_tap: got %0d want 1", TAP_POS);
        end
    endtask

    task automatic test_move_up();
        send_cmd(1'b0, 1'b1, 3, 3 * (S + 1) + 1, 4, 1'b0, 1'b0);
        wait_done("move_up");
        check_moves("move_up", 3, 1);
    endtask

    task automatic test_zero_steps();
        send_cmd(1'b0, 1'b1, 0, 2, 4, 1'b0, 1'b0);
        wait_done("zero_steps");
        check_moves("zero_steps", 0, 1);
    endtask

    task automatic test_oor_mid();
        int budget;
        send_cmd(1'b0, 1'b1, 5, 2 * (S + 1) + 1, 5, 1'b1, 1'b0);
        budget = 100;
        while (mv_q.size() < 2 && budget > 0) begin
            @(negedge FAB_CLK);
            budget--;
        end
        DELAY_LINE_OUT_OF_RANGE = 1'b1;
        wait_done("oor_mid");
        DELAY_LINE_OUT_OF_RANGE = 1'b0;
        check_moves("oor_mid", 2, 1);
    endtask

    task automatic test_oor_at_accept();
        DELAY_LINE_OUT_OF_RANGE = 1'b1;
        send_cmd(1'b0, 1'b0, 2, S + 2, 5, 1'b1, 1'b0);
        wait_done("oor_accept");
        DELAY_LINE_OUT_OF_RANGE = 1'b0;
        check_moves("oor_accept", 1, 1);
    endtask

    task automatic test_load();
        send_cmd(1'b0, 1'b1, 35, 35 * (S + 1) + 1, 40, 1'b0, 1'b0);
        wait_done("reach40");
        send_cmd(1'b1, 1'b0, 9, S + 2, 1, 1'b0, 1'b0);
        wait_done("load");
        check_moves("load", 0, 1);
        checks++;
        if (ld_q.size() != 1 || ld_q[0] != 1) begin
            errors++;
            $display("FAIL load_pulse: got %0d pulses first at %0d want 1 pulse at 1",
                     ld_q.size(), (ld_q.size() > 0) ? ld_q[0] : -1);
        end
    endtask

    task automatic test_random();
        int tap;
        int n;
        tap = 1;
        for (int i = 0; i < 4; i++) begin
            n = $urandom_range(1, 4);
            tap = tap + n;
            send_cmd(1'b0, 1'b1, n, n * (S + 1) + 1, tap, 1'b0, 1'b0);
            wait_done("random");
            check_moves("random", n, 1);
        end
    endtask

    task automatic test_wrap_or_limit();
        send_cmd(1'b1, 1'b1, 0, S + 2, 1, 1'b0, 1'b0);
        wait_done("reload");
`ifdef IOD_DLY_CTRL_SOFT_LIMIT_EN
        send_cmd(1'b0, 1'b0, 3, S + 2, 0, 1'b1, 1'b0);
        wait_done("soft_limit");
        check_moves("soft_limit", 1, 1);
`else
        send_cmd(1'b0, 1'b0, 3, 3 * (S + 1) + 1, 254, 1'b0, 1'b0);
        wait_done("wrap_down");
        check_moves("wrap_down", 3, 1);
`endif
    endtask

    task automatic test_busy_reset();
        int d0;
        send_cmd(1'b0, 1'b1, 10, 10 * (S + 1) + 1, 11, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge FAB_CLK);
            checks++;
            if (CMD_READY !== 1'b0) begin
                errors++;
                $display("FAIL busy_ready: got %b want 0", CMD_READY);
            end
        end
        @(negedge FAB_CLK);
        ARST_N = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if ({CMD_READY, DONE, DONE_OOR, DELAY_LINE_LOAD, DELAY_LINE_MOVE, TAP_POS} !== {5'b10000, 8'd1}) begin
            errors++;
            $display("FAIL midreset_outputs: got ready %b done %b oor %b load %b move %b tap %0d",
                     CMD_READY, DONE, DONE_OOR, DELAY_LINE_LOAD, DELAY_LINE_MOVE, TAP_POS);
        end
        CMD_VALID = 1'b0;
        d0 = done_cnt;
        @(negedge FAB_CLK);
        ARST_N = 1'b1;
        repeat (30) @(negedge FAB_CLK);
        checks++;
        if (done_cnt != d0 || TAP_POS !== 8'd1 || CMD_READY !== 1'b1) begin
            errors++;
            $display("FAIL after_reset: dones %0d tap %0d ready %b want 0 dones tap 1 ready 1",
                     done_cnt - d0, TAP_POS, CMD_READY);
        end
    endtask

    // sequence and final report
    initial begin
        test_reset();
        test_move_up();
        test_zero_steps();
        test_oor_mid();
        test_oor_at_accept();
        test_load();
        test_random();
        test_wrap_or_limit();
        test_busy_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
